// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
// Holds the prefetch state enum, the default queue depth and the CS:IP word-address helper.
package prefetch_pkg;

    localparam int DEFAULT_QUEUE_DEPTH = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_e;

    // 20-bit real-mode physical address, returned as the 19-bit word address [19:1].
    function automatic logic [18:0] word_addr(input logic [15:0] cs, input logic [15:0] ip);
        return 19'(({cs, 4'b0000} + {4'b0000, ip}) >> 1);
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular byte FIFO: pushes 1 or 2 bytes, pops 1, synchronous flush.
// The head byte reads as zero while the FIFO is empty.
module prefetch_fifo #(
    parameter int DEPTH = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [1:0]                   push_cnt,
    input  logic [7:0]                   push_b0,
    input  logic [7:0]                   push_b1,
    input  logic                         pop,
    output logic [7:0]                   head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_next  = ptr_inc(wr_ptr_q);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem_d[wr_ptr_q] = push_b0;
                wr_ptr_d        = wr_next;
                if (push_cnt == 2'd2) begin
                    mem_d[wr_next] = push_b1;
                    wr_ptr_d       = ptr_inc(wr_next);
                end
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push_cnt) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty = (count_q == '0);
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_prefetcher.sv
// Fetches instruction words at CS:IP into a byte queue ahead of the decoder.
// Optional PREFETCH_FLUSH_COUNT_EN adds a saturating counter of load_new_ip events.
module instruction_prefetcher
    import prefetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] new_cs,
    input  logic [15:0] new_ip,
    input  logic        load_new_ip,
    output logic        mem_access,
    output logic [18:0] mem_address,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    input  logic        q_rd_en,
    output logic [7:0]  q_data,
    output logic        q_empty,
    output logic [15:0] head_ip,
    output logic [15:0] flush_count
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0] ISSUE_MAX = CW'(QUEUE_DEPTH - 2);

    state_e        state_q, state_d;
    logic [15:0]   cs_q, cs_d;
    logic [15:0]   fetch_ip_q, fetch_ip_d;
    logic [15:0]   head_ip_q, head_ip_d;
    logic          mem_access_q, mem_access_d;
    logic [18:0]   mem_address_q, mem_address_d;

    logic [1:0]    push_cnt;
    logic          pop;
    logic          flush;
    logic          busy_after;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nxt;

    // The issue decision looks at next-cycle occupancy and address so a new request
    // can be presented the cycle right after a load, an ack or a freeing pop.
    always_comb begin
        state_d       = state_q;
        cs_d          = cs_q;
        fetch_ip_d    = fetch_ip_q;
        head_ip_d     = head_ip_q;
        mem_access_d  = mem_access_q;
        mem_address_d = mem_address_q;
        push_cnt      = 2'd0;
        pop           = 1'b0;
        flush         = 1'b0;
        busy_after    = (state_q != IDLE) && !mem_ack;
        if (load_new_ip) begin
            flush      = 1'b1;
            cs_d       = new_cs;
            fetch_ip_d = new_ip;
            head_ip_d  = new_ip;
            if (busy_after) state_d = DISCARD;
        end else begin
            if (q_rd_en && !q_empty) begin
                pop       = 1'b1;
                head_ip_d = head_ip_q + 16'd1;
            end
            if (state_q == FETCH && mem_ack) begin
                if (fetch_ip_q[0]) begin
                    push_cnt   = 2'd1;
                    fetch_ip_d = fetch_ip_q + 16'd1;
                end else begin
                    push_cnt   = 2'd2;
                    fetch_ip_d = fetch_ip_q + 16'd2;
                end
            end
        end
        count_nxt = load_new_ip ? '0 : fifo_count + CW'(push_cnt) - CW'(pop);
        if (!busy_after) begin
            if (count_nxt <= ISSUE_MAX) begin
                state_d       = FETCH;
                mem_access_d  = 1'b1;
                mem_address_d = word_addr(cs_d, fetch_ip_d);
            end else begin
                state_d      = IDLE;
                mem_access_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cs_q          <= '0;
            fetch_ip_q    <= '0;
            head_ip_q     <= '0;
            mem_access_q  <= 1'b0;
            mem_address_q <= '0;
        end else begin
            state_q       <= state_d;
            cs_q          <= cs_d;
            fetch_ip_q    <= fetch_ip_d;
            head_ip_q     <= head_ip_d;
            mem_access_q  <= mem_access_d;
            mem_address_q <= mem_address_d;
        end
    end

    // Odd fetch address: only the high byte of the word belongs to the stream.
    prefetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .flush    (flush),
        .push_cnt (push_cnt),
        .push_b0  (fetch_ip_q[0] ? mem_data[15:8] : mem_data[7:0]),
        .push_b1  (mem_data[15:8]),
        .pop      (pop),
        .head     (q_data),
        .empty    (q_empty),
        .count    (fifo_count)
    );

    assign mem_access  = mem_access_q;
    assign mem_address = mem_address_q;
    assign head_ip     = head_ip_q;

`ifdef PREFETCH_FLUSH_COUNT_EN
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        flush_count_d = flush_count_q;
        if (load_new_ip && flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flush_count_q <= '0;
        else       flush_count_q <= flush_count_d;
    end

    assign flush_count = flush_count_q;
`else
    assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Bench for instruction_prefetcher: address/byte-order table, multi-cycle corner
// sequences, and a random run against a queue-based reference model.
module tb_instruction_prefetcher;

    localparam int D = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] new_cs, new_ip;
    logic        load_new_ip;
    logic        mem_access;
    logic [18:0] mem_address;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        q_rd_en;
    logic [7:0]  q_data;
    logic        q_empty;
    logic [15:0] head_ip;
    logic [15:0] flush_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_prefetcher #(.QUEUE_DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .new_cs      (new_cs),
        .new_ip      (new_ip),
        .load_new_ip (load_new_ip),
        .mem_access  (mem_access),
        .mem_address (mem_address),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .q_rd_en     (q_rd_en),
        .q_data      (q_data),
        .q_empty     (q_empty),
        .head_ip     (head_ip),
        .flush_count (flush_count)
    );

    typedef struct {
        logic [15:0] cs;
        logic [15:0] ip;
        logic [15:0] data;
        logic [18:0] addr;
        logic [18:0] nxt;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          n;
    } vec_t;

    vec_t vecs[6];

    // reference model state
    logic [7:0]  mq[$];
    logic [15:0] m_cs, m_fip, m_head;
    bit          m_out, m_stale;
    logic [18:0] m_addr;
    int          m_loads;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int exp_fc(input int n);
`ifdef PREFETCH_FLUSH_COUNT_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [18:0] ref_addr(input logic [15:0] cs, input logic [15:0] ip);
        int unsigned phys;
        phys = (int'(cs) * 16 + int'(ip)) % (1 << 20);
        return 19'(phys / 2);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        load_new_ip = 1'b0; mem_ack = 1'b0; q_rd_en = 1'b0;
        #1;
        check("rst_access", mem_access, 0);
        check("rst_addr", mem_address, 0);
        check("rst_empty", q_empty, 1);
        check("rst_qdata", q_data, 0);
        check("rst_head", head_ip, 0);
        check("rst_flush", flush_count, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic model_init();
        mq.delete();
        m_cs = '0; m_fip = '0; m_head = '0;
        m_out = 0; m_stale = 0; m_addr = '0; m_loads = 0;
    endtask

    task automatic model_step();
        bit was_empty;
        was_empty = (mq.size() == 0);
        if (m_out && mem_ack) begin
            m_out = 0;
            if (!m_stale && !load_new_ip) begin
                if (m_fip[0]) begin
                    mq.push_back(mem_data[15:8]);
                    m_fip = m_fip + 16'd1;
                end else begin
                    mq.push_back(mem_data[7:0]);
                    mq.push_back(mem_data[15:8]);
                    m_fip = m_fip + 16'd2;
                end
            end
            m_stale = 0;
        end
        if (load_new_ip) begin
            mq.delete();
            m_cs = new_cs; m_fip = new_ip; m_head = new_ip;
            if (m_out) m_stale = 1;
            m_loads++;
        end else if (q_rd_en && !was_empty) begin
            void'(mq.pop_front());
            m_head = m_head + 16'd1;
        end
        if (!m_out && mq.size() <= D - 2) begin
            m_out  = 1;
            m_addr = ref_addr(m_cs, m_fip);
        end
    endtask

    initial begin
        int acks;
        int loads;
        logic [15:0] hip;

        vecs[0] = '{16'h1000, 16'h0010, 16'hBBAA, 19'h08008, 19'h08009, 8'hAA, 8'hBB, 2};
        vecs[1] = '{16'h0000, 16'h0011, 16'h3412, 19'h00008, 19'h00009, 8'h34, 8'h00, 1};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h5678, 19'h07FFF, 19'h00000, 8'h56, 8'h00, 1};
        vecs[3] = '{16'hF000, 16'hFFFE, 16'hCDEF, 19'h7FFFF, 19'h78000, 8'hEF, 8'hCD, 2};
        vecs[4] = '{16'hFFFF, 16'h0020, 16'h2211, 19'h00008, 19'h00009, 8'h11, 8'h22, 2};
        vecs[5] = '{16'h1234, 16'h0101, 16'hA55A, 19'h09220, 19'h09221, 8'hA5, 8'h00, 1};

        reset = 1'b1;
        new_cs = '0; new_ip = '0; load_new_ip = 1'b0;
        mem_ack = 1'b0; mem_data = '0; q_rd_en = 1'b0;
        #1;
        check("por_access", mem_access, 0);
        check("por_empty", q_empty, 1);
        check("por_head", head_ip, 0);

        // ---- table: load (with a same-cycle stale ack), fetch, pop ----
        do_reset();
        tick();
        check("first_req", mem_access, 1);
        check("first_addr", mem_address, 0);
        loads = 0;
        for (int i = 0; i < 6; i++) begin
            new_cs = vecs[i].cs; new_ip = vecs[i].ip;
            load_new_ip = 1'b1; mem_ack = 1'b1; mem_data = 16'hFFFF;
            tick();
            load_new_ip = 1'b0; mem_ack = 1'b0;
            loads++;
            check($sformatf("v%0d_empty_after_load", i), q_empty, 1);
            check($sformatf("v%0d_req", i), mem_access, 1);
            check($sformatf("v%0d_addr", i), mem_address, vecs[i].addr);
            mem_ack = 1'b1; mem_data = vecs[i].data;
            tick();
            mem_ack = 1'b0;
            check($sformatf("v%0d_nonempty", i), q_empty, 0);
            check($sformatf("v%0d_b0", i), q_data, vecs[i].b0);
            check($sformatf("v%0d_head0", i), head_ip, vecs[i].ip);
            check($sformatf("v%0d_next_req", i), mem_access, 1);
            check($sformatf("v%0d_next_addr", i), mem_address, vecs[i].nxt);
            if (vecs[i].n == 2) begin
                q_rd_en = 1'b1;
                tick();
                q_rd_en = 1'b0;
                check($sformatf("v%0d_b1", i), q_data, vecs[i].b1);
                hip = vecs[i].ip + 16'd1;
                check($sformatf("v%0d_head1", i), head_ip, hip);
            end
            q_rd_en = 1'b1;
            tick();
            q_rd_en = 1'b0;
            hip = vecs[i].ip + 16'(vecs[i].n);
            check($sformatf("v%0d_drained", i), q_empty, 1);
            check($sformatf("v%0d_head_end", i), head_ip, hip);
        end
        check("table_flush_count", flush_count, exp_fc(loads));
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
        check("pop_empty_head", head_ip, hip);
        check("pop_empty_still_empty", q_empty, 1);

        // ---- load during FETCH, stale ack two cycles later ----
        new_cs = 16'h0000; new_ip = 16'h0100;
        load_new_ip = 1'b1; mem_ack = 1'b1;
        tick();
        load_new_ip = 1'b0; mem_ack = 1'b0;
        check("disc_req0", mem_address, 19'h00080);
        new_ip = 16'h0200; load_new_ip = 1'b1;
        tick();
        load_new_ip = 1'b0;
        check("disc_hold_access", mem_access, 1);
        check("disc_hold_addr", mem_address, 19'h00080);
        tick();
        check("disc_hold2_access", mem_access, 1);
        mem_ack = 1'b1; mem_data = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        check("disc_dropped", q_empty, 1);
        check("disc_new_req", mem_access, 1);
        check("disc_new_addr", mem_address, 19'h00100);
        mem_ack = 1'b1; mem_data = 16'h2211;
        tick();
        mem_ack = 1'b0;
        check("disc_fresh_byte", q_data, 8'h11);
        check("disc_fresh_head", head_ip, 16'h0200);

        // ---- full threshold, no pops ----
        do_reset();
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            mem_ack = mem_access;
            if (mem_access) begin
                mem_data = {8'(2 * acks + 1), 8'(2 * acks)};
                acks++;
            end
            tick();
        end
        mem_ack = 1'b0;
        check("full_fetches", acks, 3);
        check("full_no_req", mem_access, 0);
        check("full_head_byte", q_data, 8'h00);
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
        check("pop1_no_req", mem_access, 0);
        check("pop1_byte", q_data, 8'h01);
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
        check("pop2_req", mem_access, 1);
        check("pop2_addr", mem_address, 19'h00003);
        check("pop2_byte", q_data, 8'h02);

        // ---- asynchronous reset with a request outstanding ----
        #2 reset = 1'b1;
        #1;
        check("midrst_access", mem_access, 0);
        check("midrst_empty", q_empty, 1);
        check("midrst_head", head_ip, 0);
        tick();
        check("midrst_next_access", mem_access, 0);
        check("midrst_next_empty", q_empty, 1);
        reset = 1'b0;

        // ---- flush counter over three loads ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            new_cs = 16'h0000; new_ip = 16'(k * 4);
            load_new_ip = 1'b1;
            tick();
            load_new_ip = 1'b0;
            tick();
        end
        check("flush_count_3", flush_count, exp_fc(3));
        check("flush_seq_empty", q_empty, 1);

        // ---- randomized run against the reference model ----
        do_reset();
        model_init();
        for (int c = 0; c < 3000; c++) begin
            check("rnd_access", mem_access, m_out);
            if (m_out) check("rnd_addr", mem_address, m_addr);
            check("rnd_empty", q_empty, mq.size() == 0);
            if (mq.size() != 0) check("rnd_qdata", q_data, mq[0]);
            check("rnd_head", head_ip, m_head);
            check("rnd_flush", flush_count, exp_fc(m_loads));
            load_new_ip = ($urandom_range(0, 24) == 0);
            new_cs      = 16'($urandom);
            new_ip      = 16'($urandom);
            mem_ack     = m_out && ($urandom_range(0, 2) == 0);
            mem_data    = 16'($urandom);
            q_rd_en     = $urandom_range(0, 1) == 1;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        load_new_ip = 1'b0; mem_ack = 1'b0; q_rd_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
